// File: rtl/btn_pkg.sv
// Shared button indices and counter sizing helper for the button conditioner.
package btn_pkg;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int NUM_BTN   = 4;

  // Width needed to count 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-FF synchroniser, debounce counter, press/release pulses
// and a saturating hold timer.
module debounce_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int HOLD_CYCLES     = 12500000
) (
  input  logic pixel_clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_hold
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int HW = cnt_width(HOLD_CYCLES);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);

  logic          sync_q1;
  logic          s_i;
  logic [DW-1:0] dcnt;
  logic [HW-1:0] hcnt;
  logic          accept;
  logic          level_nxt;

  // The synchronised input has disagreed with the level for the full window.
  always_comb begin
    accept    = (s_i != btn_level) && (dcnt == D_LAST);
    level_nxt = accept ? s_i : btn_level;
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values; blocking here would create ordering races.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      sync_q1     <= 1'b0;
      s_i         <= 1'b0;
      dcnt        <= '0;
      hcnt        <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_hold    <= 1'b0;
    end else begin
      sync_q1 <= btn_raw;
      s_i     <= sync_q1;

      // Any agreeing cycle restarts the window, which rejects glitches.
      if ((s_i == btn_level) || accept) dcnt <= '0;
      else                              dcnt <= dcnt + DW'(1);

      btn_level   <= level_nxt;
      btn_press   <= accept &  s_i;
      btn_release <= accept & ~s_i;

      if (!btn_level)           hcnt <= '0;
      else if (hcnt != H_LAST)  hcnt <= hcnt + HW'(1);

      // Uses level_nxt so hold drops on the same edge that release fires.
      btn_hold <= level_nxt && (hcnt == H_LAST);
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Four independent debounced push-button channels (up, down, left, right).
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int HOLD_CYCLES     = 12500000
) (
  input  logic       pixel_clk,
  input  logic       rst,
  input  logic [3:0] btn_raw,
  output logic [3:0] btn_level,
  output logic [3:0] btn_press,
  output logic [3:0] btn_release,
  output logic [3:0] btn_hold
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES)
    ) u_chan (
      .pixel_clk  (pixel_clk),
      .rst        (rst),
      .btn_raw    (btn_raw[i]),
      .btn_level  (btn_level[i]),
      .btn_press  (btn_press[i]),
      .btn_release(btn_release[i]),
      .btn_hold   (btn_hold[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with a per-cycle reference model.
module tb_btn_conditioner;

  localparam int DEB  = 8;
  localparam int HOLD = 20;

  logic       pixel_clk = 1'b0;
  logic       rst       = 1'b1;
  logic [3:0] btn_raw   = 4'b0;
  logic [3:0] btn_level, btn_press, btn_release, btn_hold;

  int errors = 0;
  int checks = 0;
  bit sb_en  = 1'b0;

  always #5 pixel_clk = ~pixel_clk;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES    (HOLD)
  ) dut (
    .pixel_clk  (pixel_clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_hold   (btn_hold)
  );

  // Reference model: run length of disagreement and age of the high level.
  logic [3:0] m_s1 = '0, m_s2 = '0, m_level = '0, m_press = '0, m_release = '0, m_hold = '0;
  int m_run[4];
  int m_age[4];

  always @(posedge pixel_clk) begin
    logic s2_old, lvl_old;
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_level[i] = 1'b0;
        m_press[i] = 1'b0; m_release[i] = 1'b0; m_hold[i] = 1'b0;
        m_run[i] = 0; m_age[i] = 0;
      end else begin
        s2_old  = m_s2[i];
        lvl_old = m_level[i];
        m_s2[i] = m_s1[i];
        m_s1[i] = btn_raw[i];
        m_press[i]   = 1'b0;
        m_release[i] = 1'b0;
        if (s2_old != lvl_old) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_level[i]   = s2_old;
            m_press[i]   = s2_old;
            m_release[i] = ~s2_old;
            m_run[i]     = 0;
          end
        end else begin
          m_run[i] = 0;
        end
        if (lvl_old) m_age[i]++;
        else         m_age[i] = 0;
        m_hold[i] = m_level[i] && (m_age[i] >= HOLD);
      end
    end
  end

  always @(negedge pixel_clk) begin
    if (sb_en) begin
      checks++;
      if ({btn_level, btn_press, btn_release, btn_hold} !==
          {m_level, m_press, m_release, m_hold}) begin
        errors++;
        $display("FAIL scoreboard t=%0t got lvl=%b prs=%b rel=%b hld=%b exp lvl=%b prs=%b rel=%b hld=%b",
                 $time, btn_level, btn_press, btn_release, btn_hold,
                 m_level, m_press, m_release, m_hold);
      end
      checks++;
      if ((btn_press & btn_release) !== 4'b0) begin
        errors++;
        $display("FAIL exclusive t=%0t press=%b release=%b expected no overlap",
                 $time, btn_press, btn_release);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge pixel_clk);
  endtask

  task automatic test_reset;
    rst     = 1'b1;
    btn_raw = 4'hF;
    tick(3);
    checks++;
    if ({btn_level, btn_press, btn_release, btn_hold} !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h expected 0000",
               {btn_level, btn_press, btn_release, btn_hold});
    end
    btn_raw = 4'h0;
    tick(2);
    rst   = 1'b0;
    sb_en = 1'b1;
    tick(12);
    checks++;
    if (btn_level !== 4'b0) begin
      errors++;
      $display("FAIL reset_idle_level got %b expected 0000", btn_level);
    end
  endtask

  task automatic test_clean_press;
    btn_raw[0] = 1'b1;
    tick(9);
    checks++;
    if (btn_level[0] !== 1'b0) begin
      errors++; $display("FAIL press_early got level=%b expected 0", btn_level[0]);
    end
    tick(1);
    checks++;
    if ({btn_level[0], btn_press[0]} !== 2'b11) begin
      errors++; $display("FAIL press_edge got level,press=%b expected 11", {btn_level[0], btn_press[0]});
    end
    tick(1);
    checks++;
    if ({btn_level[0], btn_press[0]} !== 2'b10) begin
      errors++; $display("FAIL press_one_cycle got level,press=%b expected 10", {btn_level[0], btn_press[0]});
    end
    btn_raw[0] = 1'b0;
    tick(10);
    checks++;
    if ({btn_level[0], btn_release[0]} !== 2'b01) begin
      errors++; $display("FAIL release_edge got level,release=%b expected 01", {btn_level[0], btn_release[0]});
    end
    tick(1);
    checks++;
    if (btn_release[0] !== 1'b0) begin
      errors++; $display("FAIL release_one_cycle got release=%b expected 0", btn_release[0]);
    end
  endtask

  task automatic test_glitch;
    logic seen;
    seen       = 1'b0;
    btn_raw[1] = 1'b1;
    for (int c = 0; c < 60; c++) begin
      tick(1);
      seen |= btn_press[1] | btn_release[1] | btn_level[1];
      if (c % 3 == 2) btn_raw[1] = ~btn_raw[1];
    end
    btn_raw[1] = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      seen |= btn_press[1] | btn_release[1] | btn_level[1];
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL glitch_reject got activity=%b expected 0", seen);
    end
  endtask

  task automatic test_hold;
    btn_raw[2] = 1'b1;
    tick(10);
    checks++;
    if ({btn_level[2], btn_press[2]} !== 2'b11) begin
      errors++; $display("FAIL hold_accept got level,press=%b expected 11", {btn_level[2], btn_press[2]});
    end
    tick(19);
    checks++;
    if (btn_hold[2] !== 1'b0) begin
      errors++; $display("FAIL hold_early got hold=%b expected 0", btn_hold[2]);
    end
    tick(1);
    checks++;
    if (btn_hold[2] !== 1'b1) begin
      errors++; $display("FAIL hold_rise got hold=%b expected 1", btn_hold[2]);
    end
    tick(20);
    checks++;
    if ({btn_level[2], btn_hold[2]} !== 2'b11) begin
      errors++; $display("FAIL hold_sustain got level,hold=%b expected 11", {btn_level[2], btn_hold[2]});
    end
    btn_raw[2] = 1'b0;
    tick(9);
    checks++;
    if ({btn_hold[2], btn_release[2]} !== 2'b10) begin
      errors++; $display("FAIL hold_before_fall got hold,release=%b expected 10", {btn_hold[2], btn_release[2]});
    end
    tick(1);
    checks++;
    if ({btn_level[2], btn_hold[2], btn_release[2]} !== 3'b001) begin
      errors++; $display("FAIL hold_clear got level,hold,release=%b expected 001",
                         {btn_level[2], btn_hold[2], btn_release[2]});
    end
  endtask

  task automatic test_simultaneous;
    btn_raw = 4'b1001;
    tick(9);
    checks++;
    if (btn_press !== 4'b0000) begin
      errors++; $display("FAIL simul_early got press=%b expected 0000", btn_press);
    end
    tick(1);
    checks++;
    if (btn_press !== 4'b1001) begin
      errors++; $display("FAIL simul_press got press=%b expected 1001", btn_press);
    end
    btn_raw = 4'b0000;
    tick(10);
    checks++;
    if (btn_release !== 4'b1001) begin
      errors++; $display("FAIL simul_release got release=%b expected 1001", btn_release);
    end
    tick(2);
  endtask

  task automatic test_reset_mid_count;
    logic seen;
    btn_raw[1] = 1'b1;
    tick(7);
    rst  = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick(1);
      seen |= (|btn_press) | (|btn_release) | (|btn_level);
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL rst_mid_quiet got activity=%b expected 0", seen);
    end
    rst = 1'b0;
    tick(9);
    checks++;
    if (btn_press[1] !== 1'b0) begin
      errors++; $display("FAIL rst_exit_early got press=%b expected 0", btn_press[1]);
    end
    tick(1);
    checks++;
    if ({btn_level[1], btn_press[1]} !== 2'b11) begin
      errors++; $display("FAIL rst_exit_press got level,press=%b expected 11", {btn_level[1], btn_press[1]});
    end
    btn_raw[1] = 1'b0;
    tick(10);
    checks++;
    if (btn_release[1] !== 1'b1) begin
      errors++; $display("FAIL rst_exit_release got release=%b expected 1", btn_release[1]);
    end
    tick(2);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_hold();
    test_simultaneous();
    test_reset_mid_count();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
